led_dim_ctrl: RTL
=================

Name: led_dim_ctrl

Overview:
- Multi-channel push-button LED controller; successor to the single-LED toggle block.
- Per channel: button synchroniser, debounce filter, and press-edge detector. Each press toggles the LED on/off or steps its brightness.
- Brightness is produced by a shared free-running PWM counter. Sits between board push-buttons and LEDs in the lab-board top level.

Parameters:
N_CH, 4, number of button/LED channels
DB_CYCLES, 16, consecutive stable cycles required to accept a button level change (>=2)
PWM_BITS, 4, brightness/PWM resolution; MAX = 2^PWM_BITS-1
STEP, 4, brightness increment per press in step mode (1..MAX)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
BTN  in  N_CH  raw asynchronous buttons, active-high, one per channel
MODE  in  1  0 = toggle mode, 1 = step mode; sampled on each press
LED  out  N_CH  PWM LED drive, registered
LEVEL  out  N_CH*PWM_BITS  current brightness per channel; channel i at [i*PWM_BITS +: PWM_BITS]
PRESS  out  N_CH  one-cycle accepted-press pulse per channel (debug/status)

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset: all state is cleared on the CLK edge while RST=1: sync FFs, debounced state db, db_prev, debounce counters, levels, PWM counter, LED. Reset values are LED=0, LEVEL=0, PRESS=0.
- Reset mid-operation: all state is cleared, including debounce progress and levels. A button held through reset is seen as a fresh 0->1 change and yields one press after debounce completes.
- Synchroniser: two FFs per channel (s1, s2).
- Debounce, per channel, using counter cnt of width clog2(DB_CYCLES):
  - If s2==db: cnt<=0.
  - Else if cnt==DB_CYCLES-1: db<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
  - Any glitch where s2 returns to db before acceptance restarts the count from 0.
- Edge detect: db_prev<=db every cycle. PRESS[i] = db[i] & ~db_prev[i], combinational from registers. Release edges generate nothing.
- Latency: BTN rises and stays high, first sampled at edge e0.
  - db=1 after edge e(DB_CYCLES+1).
  - PRESS=1 for exactly the cycle between e(DB_CYCLES+1) and e(DB_CYCLES+2).
  - LEVEL updates at e(DB_CYCLES+2).
  - LED reflects the new level from e(DB_CYCLES+3).
- Level update on PRESS[i]:
  - MODE=0: level<=(level==0)?MAX:0.
  - MODE=1: compute sum=level+STEP in PWM_BITS+1 bits. level<=(sum>MAX)?0:sum, i.e. it wraps to 0 rather than saturating.
  - MODE changes between presses never alter existing levels.
- Channels are fully independent; simultaneous presses on several channels all update in the same cycle.
- PWM: a shared counter pc of PWM_BITS width increments every cycle and wraps MAX->0 (period 2^PWM_BITS). Registered output: LED[i] <= (level[i]==MAX) ? 1 : (pc < level[i]).
  - level=0 gives LED constantly 0.
  - level=MAX gives LED constantly 1.
  - Otherwise the duty is level/2^PWM_BITS.
- BTN held indefinitely yields exactly one PRESS; the level is not re-toggled every cycle.

Test Plan:
- Toggle press (DB_CYCLES=4, MODE=0): hold BTN[0]=1 for 20 cycles from e0 -> PRESS[0] high only in the cycle after e5, LEVEL[0] 0->15 at e6, LED[0] constant 1 from e7; other channels stay 0.
- Bounce rejection: BTN[1] pulses 1 for 3 cycles, 0 for 1, repeated 5 times -> PRESS[1] never asserts, LEVEL[1] stays 0. Then hold high 10 cycles -> exactly one PRESS.
- Step and wrap (MODE=1, STEP=4): 4 clean presses -> LEVEL 4, 8, 12, 0. Then a press with STEP=5 from 12 -> 0, not 17 truncated.
- PWM duty (LEVEL=4, PWM_BITS=4): LED high exactly 4 of every 16 cycles in steady state, contiguous while pc=0..3.
- Simultaneous and independent: press channels 0 and 3 in the same cycle (MODE=0) -> both LEVELs become 15 on the same edge; channels 1 and 2 are unaffected.
- Reset mid-operation: assert RST for 1 cycle with levels nonzero and BTN[2] held -> all outputs 0 next cycle. With BTN[2] still held, one PRESS[2] follows DB_CYCLES+2 edges after RST deasserts.

Source files
------------

// File: rtl/led_dim_ctrl.sv
// led_dim_ctrl: multi-channel push-button LED controller.
// Each channel synchronises and debounces its button and detects press edges.
// A press toggles the LED between off and full brightness, or steps the brightness up.
// A shared free-running PWM counter turns each channel's level into a duty cycle.
module led_dim_ctrl #(
  parameter int N_CH      = 4,
  parameter int DB_CYCLES = 16,
  parameter int PWM_BITS  = 4,
  parameter int STEP      = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_CH-1:0]          BTN,
  input  logic                     MODE,
  output logic [N_CH-1:0]          LED,
  output logic [N_CH*PWM_BITS-1:0] LEVEL,
  output logic [N_CH-1:0]          PRESS
);

  localparam int                  CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]       CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS + 1)'(STEP);

  logic [N_CH-1:0]     s1;
  logic [N_CH-1:0]     s2;
  logic [N_CH-1:0]     db;
  logic [N_CH-1:0]     db_prev;
  logic [CW-1:0]       cnt       [N_CH];
  logic [PWM_BITS-1:0] level     [N_CH];
  logic [PWM_BITS-1:0] level_nxt [N_CH];
  logic [PWM_BITS-1:0] pc;

  // Next brightness for one press. The step sum carries one extra bit so
  // that overflow wraps to zero instead of truncating.
  function automatic logic [PWM_BITS-1:0] next_level(
    input logic [PWM_BITS-1:0] cur,
    input logic                mode
  );
    logic [PWM_BITS:0] sum;
    sum = {1'b0, cur} + STEP_EXT;
    if (mode == 1'b0) begin
      next_level = (cur == {PWM_BITS{1'b0}}) ? MAX : {PWM_BITS{1'b0}};
    end else if (sum > {1'b0, MAX}) begin
      next_level = {PWM_BITS{1'b0}};
    end else begin
      next_level = sum[PWM_BITS-1:0];
    end
  endfunction

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= {N_CH{1'b0}};
      s2 <= {N_CH{1'b0}};
    end else begin
      s1 <= BTN;
      s2 <= s1;
    end
  end

  // Debounce: accept a new level only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      db      <= {N_CH{1'b0}};
      db_prev <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= {CW{1'b0}};
      end
    end else begin
      db_prev <= db;
      for (int i = 0; i < N_CH; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= {CW{1'b0}};
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= {CW{1'b0}};
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level is an accepted press; releases are ignored.
  assign PRESS = db & ~db_prev;

  // Per-channel brightness update on an accepted press.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      level_nxt[i] = level[i];
      if (PRESS[i]) begin
        level_nxt[i] = next_level(level[i], MODE);
      end else begin
        level_nxt[i] = level[i];
      end
    end
  end

  // Brightness registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        level[i] <= {PWM_BITS{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        level[i] <= level_nxt[i];
      end
    end
  end

  // Shared free-running PWM counter, wraps naturally at MAX.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc <= {PWM_BITS{1'b0}};
    end else begin
      pc <= pc + PWM_BITS'(1);
    end
  end

  // Registered LED drive; full level forces the LED solidly on.
  always_ff @(posedge CLK) begin
    if (RST) begin
      LED <= {N_CH{1'b0}};
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        LED[i] <= (level[i] == MAX) | (pc < level[i]);
      end
    end
  end

  // Pack the per-channel levels onto the status bus.
  always_comb begin
    LEVEL = {(N_CH*PWM_BITS){1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      LEVEL[i*PWM_BITS +: PWM_BITS] = level[i];
    end
  end

endmodule
